data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Word-addressed data memory that answers the processor datapath's load/store requests (ALU address, register write data, memory-write control) through a request/ready handshake.
- Inserts a configurable number of wait states, so later multi-cycle and pipelined cores can stall on it.
- Flags misaligned and out-of-range accesses instead of performing them.

Parameters:
DEPTH, 64, number of 32-bit words stored; legal byte addresses are 0 to 4*DEPTH-4.
WAIT_CYCLES, 2, wait states inserted before the response; legal range 0..15.

Ports:
CLK  input  1  clock; all state changes on its rising edge.
rst  input  1  asynchronous, active-low reset.
MemReq  input  1  request strobe; sampled only when Busy=0.
MemWrite  input  1  1 = store, 0 = load; captured with MemReq.
Addr  input  32  byte address from the ALU result; captured with MemReq.
WriteData  input  32  store data; captured with MemReq.
ReadData  output  32  load data; registered.
MemReady  output  1  one-cycle completion pulse.
MemErr  output  1  qualifies MemReady; 1 = access rejected.
Busy  output  1  high while a request is in flight; new requests are ignored.

Behaviour:
- Reset (rst=0, asynchronous):
  - state returns to IDLE; ReadData=0, MemReady=0, MemErr=0, Busy=0, wait counter=0.
  - Storage array contents are not reset.
  - Reset mid-operation aborts the request. A pending store is discarded and no response is produced.
- States: IDLE, WAIT, DONE.
- IDLE:
  - On a rising edge with MemReq=1, the block captures Addr, WriteData and MemWrite, and Busy=1 from that edge.
  - Error check on the captured Addr: error if Addr[1:0]!=0 or Addr[31:2]>=DEPTH.
  - If error: go to DONE at the same edge with MemReady=1 and MemErr=1. ReadData is forced to 0 and no store occurs, regardless of WAIT_CYCLES.
  - Else if WAIT_CYCLES=0: perform the access at the same edge and go to DONE with MemReady=1 and MemErr=0.
  - Else: go to WAIT and load the counter with WAIT_CYCLES-1.
- WAIT:
  - Each edge decrements the counter.
  - On the edge where the counter is 0, perform the access, go to DONE and set MemReady=1.
- Access:
  - Store writes the captured WriteData to word Addr[31:2]; ReadData is unchanged.
  - Load sets ReadData to the stored word.
- DONE:
  - MemReady is high for exactly one cycle.
  - The next edge returns to IDLE with MemReady=0, MemErr=0 and Busy=0.
  - MemReq seen in DONE is ignored; the requester must hold or re-assert it.
- Latency: MemReady rises WAIT_CYCLES edges after the accepting edge, or at the accepting edge itself for an error or WAIT_CYCLES=0.
- Throughput: one request per WAIT_CYCLES+2 cycles at most.
- Input stability: Addr, WriteData and MemWrite changes after the accepting edge have no effect.
- ReadData holds its value until the next successful load completes, or is forced to 0 by an error or reset.
- MemErr is never high unless MemReady is high.
- Address decode uses only Addr[31:2] compared against DEPTH. There is no wrap-around: an address of 4*DEPTH or above is an error, not aliased.

Test Plan:
- Reset value and mid-operation reset:
  - Assert rst=0 for 2 cycles -> ReadData=0, MemReady=0, MemErr=0, Busy=0.
  - Store 0x12345678 to 0x20; pull rst=0 during WAIT; then load 0x20 after previously writing 0xAAAAAAAA there -> ReadData=0xAAAAAAAA.
- Store then load, WAIT_CYCLES=2:
  - Store 0xDEADBEEF to 0x10 -> MemReady pulses 2 edges after accept, MemErr=0, Busy high for 3 cycles.
  - Load 0x10 -> ReadData=0xDEADBEEF on the MemReady cycle.
- Misaligned store to 0x13 -> MemReady=1 and MemErr=1 on the accepting edge, ReadData=0; a subsequent load of 0x10 still returns 0xDEADBEEF.
- Range boundary, DEPTH=64:
  - Store and load at 0xFC -> succeeds with data intact.
  - Access at 0x100 -> MemErr=1 with no write.
  - Access at 0xFFFFFFFC -> MemErr=1.
- Capture check: accept a store of 0x0000CAFE at 0x08, then change Addr to 0x0C and WriteData to 0xFFFFFFFF during WAIT -> 0x08 holds 0x0000CAFE and 0x0C is unchanged.
- WAIT_CYCLES=0 build with MemReq held high continuously -> MemReady pulses every 2nd cycle, Busy toggles, and every ready cycle carries the correct data.

Source files
------------

// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind a request/ready handshake with configurable wait states.
// Rejects misaligned and out-of-range addresses with an error response instead of accessing storage.
module data_mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        MemErr,
  output logic        Busy
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);
  localparam logic [3:0]  WAIT_W  = 4'(WAIT_CYCLES);

  logic [31:0]   mem_q [DEPTH];
  state_e        state_q;
  logic [3:0]    cnt_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          we_q;
  logic [31:0]   rdata_q;
  logic          ready_q;
  logic          err_q;
  logic          busy_q;

  logic          req_err;
  logic [AW-1:0] req_idx;
  logic          acc_go;
  logic          acc_we;
  logic [AW-1:0] acc_idx;
  logic [31:0]   acc_wdata;

  // The full word index is range-checked, so high addresses are rejected rather than aliased.
  assign req_err = (Addr[1:0] != 2'b00) || (Addr[31:2] >= DEPTH_W);
  assign req_idx = Addr[AW+1:2];

  // Access strobe: straight from the inputs on a zero-wait accept, else from the captured request.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    acc_go    = 1'b0;
    acc_we    = we_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    case (state_q)
      IDLE: begin
        if (MemReq && !req_err && (WAIT_CYCLES == 0)) begin
          acc_go    = 1'b1;
          acc_we    = MemWrite;
          acc_idx   = req_idx;
          acc_wdata = WriteData;
        end
      end
      WAIT:    acc_go = (cnt_q == 4'd0);
      default: acc_go = 1'b0;
    endcase
  end

  // NOTE: storage has no reset; gating with rst keeps an aborted store from landing.
  always_ff @(posedge CLK) begin
    if (rst && acc_go && acc_we) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      if (acc_go && !acc_we) begin
        rdata_q <= mem_q[acc_idx];
      end
      case (state_q)
        IDLE: begin
          if (MemReq) begin
            busy_q  <= 1'b1;
            idx_q   <= req_idx;
            wdata_q <= WriteData;
            we_q    <= MemWrite;
            if (req_err) begin
              state_q <= DONE;
              ready_q <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= 32'd0;
            end else if (WAIT_CYCLES == 0) begin
              state_q <= DONE;
              ready_q <= 1'b1;
            end else begin
              state_q <= WAIT;
              cnt_q   <= WAIT_W - 4'd1;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= DONE;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ReadData = rdata_q;
  assign MemReady = ready_q;
  assign MemErr   = err_q;
  assign Busy     = busy_q;

endmodule
